// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: opcodes, directions, player
// state encoding, instruction field positions and the axis clamp helper.
package game_pkg;

  // Instruction field positions: {op[15:12], operand[11:4], pad[3:0]}
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int ARG_HI = 11;
  localparam int ARG_LO = 4;

  // Player opcodes
  localparam logic [3:0] OP_HPY = 4'd1;
  localparam logic [3:0] OP_DPY = 4'd2;
  localparam logic [3:0] OP_IDG = 4'd3;
  localparam logic [3:0] OP_SDG = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_SHP = 4'd6;

  // MOV directions (operand values)
  localparam logic [7:0] DIR_UP    = 8'd0;
  localparam logic [7:0] DIR_LEFT  = 8'd1;
  localparam logic [7:0] DIR_DOWN  = 8'd2;
  localparam logic [7:0] DIR_RIGHT = 8'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DEAD   = 2'd2
  } player_state_t;

  // Add a signed step to a position and saturate at [lo, hi]; 11-bit signed
  // arithmetic so a step below zero can never wrap into a large value.
  function automatic logic [9:0] step_clamp(input logic [9:0] pos,
                                            input logic signed [10:0] delta,
                                            input logic [9:0] lo,
                                            input logic [9:0] hi);
    logic signed [10:0] sum;
    sum = $signed({1'b0, pos}) + delta;
    if (sum < $signed({1'b0, lo})) begin
      return lo;
    end else if (sum > $signed({1'b0, hi})) begin
      return hi;
    end else begin
      return sum[9:0];
    end
  endfunction

endpackage

// File: rtl/move_ticker.sv
// Clock divider producing a one-cycle tick every DIV enabled cycles.
// The count is held at zero while disabled or cleared, so the first tick
// after (re)start always comes DIV cycles later.
module move_ticker #(
  parameter int DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  // Free-running 0..DIV-1 counter while enabled, parked at 0 otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {W{1'b0}};
    end else if (clear || !enable) begin
      count <= {W{1'b0}};
    end else if (count == LAST) begin
      count <= {W{1'b0}};
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/player_executor.sv
// Player instruction executor: heart position, HP and IDLE/ACTIVE/DEAD status.
// Optional feature macro: PLAYER_IFRAME_EN (invulnerability frames after damage).
module player_executor
  import game_pkg::*;
#(
  parameter int X_MIN    = 220,
  parameter int X_MAX    = 420,
  parameter int Y_MIN    = 240,
  parameter int Y_MAX    = 400,
  parameter int STEP     = 4,
  parameter int MOVE_DIV = 1_000_000,
  parameter int HP_MAX   = 20,
  parameter int IFRAMES  = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] playerInstruction,
  input  logic        isMove,
  output logic [9:0]  playerX,
  output logic [9:0]  playerY,
  output logic [7:0]  hp,
  output logic        isDeath,
  output logic        dodging,
  output logic        invuln
);

  localparam logic [9:0]         X_LO   = 10'(X_MIN);
  localparam logic [9:0]         X_HI   = 10'(X_MAX);
  localparam logic [9:0]         Y_LO   = 10'(Y_MIN);
  localparam logic [9:0]         Y_HI   = 10'(Y_MAX);
  localparam logic [9:0]         X_CTR  = 10'((X_MIN + X_MAX) / 2);
  localparam logic [9:0]         Y_CTR  = 10'((Y_MIN + Y_MAX) / 2);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic [7:0]         HP_CAP = 8'(HP_MAX);

  player_state_t state;
  logic [3:0] op;
  logic [7:0] arg;
  logic       unused_pad;
  logic       tick;
  logic       alive;
  logic       dpy_ok;
  logic       death;
  logic       idg_exec;
  logic       leave_active;
  logic [8:0] hp_sum;
  logic [7:0] hpy_val;
  logic [7:0] dpy_val;
  logic [7:0] shp_val;
  logic [9:0] mov_x;
  logic [9:0] mov_y;

  assign op         = playerInstruction[OP_HI:OP_LO];
  assign arg        = playerInstruction[ARG_HI:ARG_LO];
  assign unused_pad = ^playerInstruction[3:0];
  assign alive      = (state != ST_DEAD);

`ifdef PLAYER_IFRAME_EN
  localparam int IW = $clog2(IFRAMES + 1);
  logic [IW-1:0] ifr_cnt;
  logic          ifr_load;

  assign dpy_ok   = (ifr_cnt == {IW{1'b0}});
  assign ifr_load = isMove && alive && (op == OP_DPY) && dpy_ok && (arg != 8'd0);

  // I-frame counter: reload on damage, otherwise count down to zero in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      ifr_cnt <= {IW{1'b0}};
      invuln  <= 1'b0;
    end else if (ifr_load) begin
      ifr_cnt <= IW'(IFRAMES);
      invuln  <= (IFRAMES != 0);
    end else if (ifr_cnt != {IW{1'b0}}) begin
      ifr_cnt <= ifr_cnt - IW'(1);
      invuln  <= (ifr_cnt > IW'(1));
    end else begin
      invuln  <= 1'b0;
    end
  end
`else
  assign dpy_ok = 1'b1;
  assign invuln = 1'b0;
`endif

  // HP candidates: saturating heal, floor-at-zero damage, capped set
  always_comb begin
    hp_sum = {1'b0, hp} + {1'b0, arg};
    if (hp_sum > {1'b0, HP_CAP}) begin
      hpy_val = HP_CAP;
    end else begin
      hpy_val = hp_sum[7:0];
    end
    if (arg >= hp) begin
      dpy_val = 8'd0;
    end else begin
      dpy_val = hp - arg;
    end
    if (arg > HP_CAP) begin
      shp_val = HP_CAP;
    end else begin
      shp_val = arg;
    end
  end

  // Candidate heart position for a MOV; unknown directions leave it in place
  always_comb begin
    mov_x = playerX;
    mov_y = playerY;
    case (arg)
      DIR_UP:    mov_y = step_clamp(playerY, -STEP_S, Y_LO, Y_HI);
      DIR_LEFT:  mov_x = step_clamp(playerX, -STEP_S, X_LO, X_HI);
      DIR_DOWN:  mov_y = step_clamp(playerY, STEP_S, Y_LO, Y_HI);
      DIR_RIGHT: mov_x = step_clamp(playerX, STEP_S, X_LO, X_HI);
      default: begin
        mov_x = playerX;
        mov_y = playerY;
      end
    endcase
  end

  assign death = isMove && alive &&
                 (((op == OP_DPY) && dpy_ok && (dpy_val == 8'd0)) ||
                  ((op == OP_SHP) && (shp_val == 8'd0)));
  assign idg_exec     = isMove && alive && (op == OP_IDG);
  assign leave_active = (state == ST_ACTIVE) && isMove && ((op == OP_SDG) || death);

  move_ticker #(.DIV(MOVE_DIV)) u_ticker (
    .clk    (clk),
    .reset  (reset),
    .enable (state == ST_ACTIVE),
    .clear  (idg_exec || leave_active),
    .tick   (tick)
  );

  // Player FSM with registered position, HP and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      playerX <= X_CTR;
      playerY <= Y_CTR;
      hp      <= HP_CAP;
      isDeath <= 1'b0;
      dodging <= 1'b0;
    end else if (isMove) begin
      if (state == ST_DEAD) begin
        if ((op == OP_SHP) && (arg != 8'd0)) begin
          state   <= ST_IDLE;
          hp      <= shp_val;
          playerX <= X_CTR;
          playerY <= Y_CTR;
          isDeath <= 1'b0;
          dodging <= 1'b0;
        end
      end else begin
        case (op)
          OP_IDG: begin
            state   <= ST_ACTIVE;
            playerX <= X_CTR;
            playerY <= Y_CTR;
            dodging <= 1'b1;
          end
          OP_SDG: begin
            state   <= ST_IDLE;
            dodging <= 1'b0;
          end
          OP_MOV: begin
            if ((state == ST_ACTIVE) && tick) begin
              playerX <= mov_x;
              playerY <= mov_y;
            end
          end
          OP_HPY: hp <= hpy_val;
          OP_DPY: begin
            if (dpy_ok) begin
              hp <= dpy_val;
            end
          end
          OP_SHP: hp <= shp_val;
          default: ;
        endcase
        if (death) begin
          state   <= ST_DEAD;
          isDeath <= 1'b1;
          dodging <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_player_executor.sv
// Scoreboard bench for player_executor (MOVE_DIV=4, IFRAMES=10).
// A behavioural reference model predicts the outputs after every edge.
module tb_player_executor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] playerInstruction = 16'h0000;
  logic        isMove = 1'b0;
  logic [9:0]  playerX;
  logic [9:0]  playerY;
  logic [7:0]  hp;
  logic        isDeath;
  logic        dodging;
  logic        invuln;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: 0 IDLE, 1 ACTIVE, 2 DEAD
  int m_st, m_x, m_y, m_hp, m_tk, m_if;
  logic [31:0] sb[$];

  player_executor #(.MOVE_DIV(4), .IFRAMES(10)) dut (
    .clk               (clk),
    .reset             (reset),
    .playerInstruction (playerInstruction),
    .isMove            (isMove),
    .playerX           (playerX),
    .playerY           (playerY),
    .hp                (hp),
    .isDeath           (isDeath),
    .dodging           (dodging),
    .invuln            (invuln)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ins(input int op, input int arg);
    logic [3:0] o;
    logic [7:0] a;
    logic [3:0] pad;
    o = 4'(op);
    a = 8'(arg);
    pad = 4'($urandom_range(0, 15));
    return {o, a, pad};
  endfunction

  function automatic logic [31:0] exp_word();
    return {1'b0, 10'(m_x), 10'(m_y), 8'(m_hp), (m_st == 2), (m_st == 1), (m_if != 0)};
  endfunction

  function automatic logic [31:0] obs_word();
    return {1'b0, playerX, playerY, hp, isDeath, dodging, invuln};
  endfunction

  task automatic model(input bit rst, input logic [15:0] instr, input bit mv);
    int op, arg;
    bit tk_hit, was_act, clr, load, dpy_ok;
    if (rst) begin
      m_st = 0; m_x = 320; m_y = 320; m_hp = 20; m_tk = 0; m_if = 0;
      return;
    end
    op = int'(instr[15:12]);
    arg = int'(instr[11:4]);
    tk_hit = (m_st == 1) && (m_tk == 3);
    was_act = (m_st == 1);
    clr = 1'b0;
    load = 1'b0;
`ifdef PLAYER_IFRAME_EN
    dpy_ok = (m_if == 0);
`else
    dpy_ok = 1'b1;
`endif
    if (mv) begin
      if (m_st == 2) begin
        if (op == 6 && arg != 0) begin
          m_hp = (arg > 20) ? 20 : arg;
          m_st = 0; m_x = 320; m_y = 320;
        end
      end else begin
        case (op)
          3: begin m_st = 1; m_x = 320; m_y = 320; clr = 1'b1; end
          4: m_st = 0;
          5: if (tk_hit) begin
               case (arg)
                 0: m_y = (m_y - 4 < 240) ? 240 : m_y - 4;
                 1: m_x = (m_x - 4 < 220) ? 220 : m_x - 4;
                 2: m_y = (m_y + 4 > 400) ? 400 : m_y + 4;
                 3: m_x = (m_x + 4 > 420) ? 420 : m_x + 4;
                 default: ;
               endcase
             end
          1: m_hp = (m_hp + arg > 20) ? 20 : m_hp + arg;
          2: if (dpy_ok) begin
               m_hp = (arg >= m_hp) ? 0 : m_hp - arg;
               load = (arg != 0);
               if (m_hp == 0) m_st = 2;
             end
          6: begin
               m_hp = (arg > 20) ? 20 : arg;
               if (m_hp == 0) m_st = 2;
             end
          default: ;
        endcase
      end
    end
    if (m_st == 1 && was_act && !clr) m_tk = (m_tk + 1) % 4;
    else m_tk = 0;
`ifdef PLAYER_IFRAME_EN
    if (load) m_if = 10;
    else if (m_if > 0) m_if = m_if - 1;
`else
    m_if = 0;
`endif
  endtask

  // Drive one cycle, push the prediction, then pop and compare after the edge
  task automatic step(input bit rst, input logic [15:0] instr, input bit mv);
    logic [31:0] e;
    reset = rst;
    playerInstruction = instr;
    isMove = mv;
    model(rst, instr, mv);
    sb.push_back(exp_word());
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("sb", obs_word(), e);
    end
    reset = 1'b0;
    isMove = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, ins(0, 0), 1'b0);
  endtask

  initial begin
    // Reset
    step(1'b1, ins(5, 3), 1'b1);
    step(1'b1, ins(0, 0), 1'b0);
    check_eq("reset_x", 32'(playerX), 32'd320);
    check_eq("reset_y", 32'(playerY), 32'd320);
    check_eq("reset_hp", 32'(hp), 32'd20);
    check_eq("reset_flags", {29'd0, isDeath, dodging, invuln}, 32'd0);

    // IDG then MOV RIGHT every cycle for 16 cycles
    step(1'b0, ins(3, 0), 1'b1);
    check_eq("idg_dodging", 32'(dodging), 32'd1);
    for (int i = 0; i < 16; i++) step(1'b0, ins(5, 3), 1'b1);
    check_eq("right16_x", 32'(playerX), 32'd336);
    check_eq("right16_y", 32'(playerY), 32'd320);

    // 30 tick-aligned MOV LEFT saturate at X_MIN
    for (int i = 0; i < 30; i++) begin
      idle(3);
      step(1'b0, ins(5, 1), 1'b1);
    end
    check_eq("left_clamp_x", 32'(playerX), 32'd220);

    // Unknown direction on a tick does nothing; one DOWN moves
    idle(3);
    step(1'b0, ins(5, 9), 1'b1);
    idle(3);
    step(1'b0, ins(5, 2), 1'b1);
    check_eq("down_y", 32'(playerY), 32'd324);

    // Stop dodging: position held
    step(1'b0, ins(4, 0), 1'b1);
    check_eq("sdg_x", 32'(playerX), 32'd220);
    check_eq("sdg_dodging", 32'(dodging), 32'd0);

    // Damage with i-frames
    step(1'b0, ins(2, 5), 1'b1);
    check_eq("dpy1_hp", 32'(hp), 32'd15);
    idle(2);
    step(1'b0, ins(2, 5), 1'b1);
`ifdef PLAYER_IFRAME_EN
    check_eq("dpy2_hp", 32'(hp), 32'd15);
    check_eq("dpy2_invuln", 32'(invuln), 32'd1);
`else
    check_eq("dpy2_hp", 32'(hp), 32'd10);
`endif
    idle(11);
    step(1'b0, ins(2, 5), 1'b1);
`ifdef PLAYER_IFRAME_EN
    check_eq("dpy3_hp", 32'(hp), 32'd10);
`else
    check_eq("dpy3_hp", 32'(hp), 32'd5);
`endif
    idle(12);

    // Death and DEAD-state filtering
    step(1'b0, ins(6, 20), 1'b1);
    step(1'b0, ins(2, 25), 1'b1);
    check_eq("death_hp", 32'(hp), 32'd0);
    check_eq("death_flag", 32'(isDeath), 32'd1);
    step(1'b0, ins(3, 0), 1'b1);
    step(1'b0, ins(5, 3), 1'b1);
    step(1'b0, ins(1, 5), 1'b1);
    step(1'b0, ins(6, 0), 1'b1);
    check_eq("dead_hp", 32'(hp), 32'd0);
    check_eq("dead_x", 32'(playerX), 32'd220);
    step(1'b0, ins(6, 12), 1'b1);
    check_eq("revive_hp", 32'(hp), 32'd12);
    check_eq("revive_pos", {12'd0, playerX, playerY}, {12'd0, 10'd320, 10'd320});
    check_eq("revive_flag", 32'(isDeath), 32'd0);

    // Heal saturation, SHP 0 death, SHP cap
    step(1'b0, ins(1, 3), 1'b1);
    step(1'b0, ins(1, 200), 1'b1);
    check_eq("hpy_cap", 32'(hp), 32'd20);
    step(1'b0, ins(6, 0), 1'b1);
    check_eq("shp0_dead", 32'(isDeath), 32'd1);
    step(1'b0, ins(6, 250), 1'b1);
    check_eq("shp_cap", 32'(hp), 32'd20);

    // Top clamp
    step(1'b0, ins(3, 0), 1'b1);
    for (int i = 0; i < 22; i++) begin
      idle(3);
      step(1'b0, ins(5, 0), 1'b1);
    end
    check_eq("up_clamp_y", 32'(playerY), 32'd240);

    // Reset mid-operation with pending DPY and live i-frames
    step(1'b0, ins(3, 0), 1'b1);
    step(1'b0, ins(6, 12), 1'b1);
    step(1'b0, ins(2, 5), 1'b1);
    idle(1);
    step(1'b0, ins(5, 0), 1'b1);
    check_eq("pre_reset_hp", 32'(hp), 32'd7);
    step(1'b1, ins(2, 5), 1'b1);
    check_eq("rst_hp", 32'(hp), 32'd20);
    check_eq("rst_flags", {29'd0, isDeath, dodging, invuln}, 32'd0);
    check_eq("rst_pos", {12'd0, playerX, playerY}, {12'd0, 10'd320, 10'd320});
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
